// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int WIDTH_DEFAULT = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between the operand source and the serial subtractor.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, d, b_out, zero, neg, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, b_out, zero, neg, ovf
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: di = ai - bi - bin, with borrow out.
module full_subtractor (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic di,
    output logic bout
);
    assign di   = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~(ai ^ bi) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b, LSB first, one bit per clock.
// Results and flags are registered together on the last bit and held until the next one.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] d_sr;
    logic [WIDTH-1:0] d_final;
    logic [WIDTH-1:0] d_q;
    logic             borrow;
    logic [IDX_W-1:0] idx;
    logic             a_msb;
    logic             b_msb;
    logic             bit_d;
    logic             bit_borrow;
    logic             last_bit;
    logic             b_out_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;

    full_subtractor u_fs (
        .ai   (a_sr[0]),
        .bi   (b_sr[0]),
        .bin  (borrow),
        .di   (bit_d),
        .bout (bit_borrow)
    );

    assign last_bit = (idx == IDX_W'(WIDTH - 1));
    // The final bit is merged combinationally so the result lands on DONE entry.
    assign d_final  = {bit_d, d_sr};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            d_sr    <= '0;
            borrow  <= 1'b0;
            idx     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            d_q     <= '0;
            b_out_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        borrow <= 1'b0;
                        idx    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    d_sr   <= d_final[WIDTH-1:1];
                    borrow <= bit_borrow;
                    idx    <= idx + 1'b1;
                    if (last_bit) begin
                        d_q     <= d_final;
                        b_out_q <= bit_borrow;
                        zero_q  <= (d_final == '0);
                        neg_q   <= bit_d;
                        ovf_q   <= (a_msb ^ b_msb) & (a_msb ^ bit_d);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.d     = d_q;
    assign bus.b_out = b_out_q;
    assign bus.zero  = zero_q;
    assign bus.neg   = neg_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=13), checked with immediate assertions.
module tb_serial_subtractor;
    localparam int W = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt;
    int   busy_cnt;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse, wait for done (bounded), check latency and busy length.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        cnt       = 0;
        busy_cnt  = 0;
        while (!bus.done && cnt < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, W);
        chk({tag, "_busy_cycles"}, busy_cnt, W);
    endtask

    task automatic chk_result(input string tag, input logic [W-1:0] d, input logic bo,
                              input logic z, input logic n, input logic o);
        chk({tag, "_d"},     bus.d,     d);
        chk({tag, "_b_out"}, bus.b_out, bo);
        chk({tag, "_zero"},  bus.zero,  z);
        chk({tag, "_neg"},   bus.neg,   n);
        chk({tag, "_ovf"},   bus.ovf,   o);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk_result("reset", 13'h0, 0, 0, 0, 0);
        rst = 1'b0;

        run_op("v1", 13'd100, 13'h1FF6);
        chk_result("v1", 13'd110, 1, 0, 0, 0);
        @(negedge clk);
        chk("v1_done_one_cycle", bus.done, 0);
        chk("v1_hold_d", bus.d, 13'd110);

        run_op("v2", 13'h1FF6, 13'd100);
        chk_result("v2", 13'h1F92, 0, 0, 1, 0);

        run_op("v3", 13'd4095, 13'h1FFF);
        chk_result("v3", 13'h1000, 1, 0, 1, 1);

        run_op("v4", 13'd63, 13'd63);
        chk_result("v4", 13'h0000, 0, 1, 0, 0);

        run_op("v5", 13'd0, 13'd1);
        chk_result("v5", 13'h1FFF, 1, 0, 1, 0);

        run_op("v6", 13'h1000, 13'd1);
        chk_result("v6", 13'h0FFF, 0, 0, 0, 1);

        // Second start mid-run must be ignored; outputs hold old result meanwhile.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 13'd1000;
        bus.b     = 13'd15;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 13'd7;
        bus.b     = 13'd3;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_hold_d_mid_run", bus.d, 13'h0FFF);
        chk("ign_busy_mid_run", bus.busy, 1);
        cnt = 0;
        while (!bus.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("ign_latency_rest", cnt, W - 5);
        chk_result("ign", 13'd985, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("ign_no_second_done", bus.done, 0);
        chk("ign_idle_busy", bus.busy, 0);

        // Reset mid-run aborts and clears outputs.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 13'd500;
        bus.b     = 13'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk_result("rst", 13'h0, 0, 0, 0, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("rst_no_done_pulse", cnt, 0);

        run_op("after_rst", 13'd500, 13'd20);
        chk_result("after_rst", 13'd480, 0, 0, 0, 0);

        // Start held high: back-to-back operations with period WIDTH+2.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 13'd9;
        bus.b     = 13'd4;
        cnt = 0;
        while (!bus.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        cnt = 1;
        while (!bus.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("held_period", cnt, W + 2);
        chk("held_d", bus.d, 13'd5);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
